// File: rtl/sipo_rx.sv
// sipo_rx: serial-in parallel-out receiver.
// Collects a framed serial bitstream into WIDTH-bit words.
// Each finished word is presented on a held parallel output with a
// valid/ready handshake.
// Optional feature macro: SIPO_RX_PARITY_EN. When it is defined, each frame
// carries an even-parity bit after the data bits, and that bit is checked.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef SIPO_RX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_word;
    logic               w_complete;
    logic               w_accept;
`ifdef SIPO_RX_PARITY_EN
    logic               w_perr;
`endif

    // The new bit enters at the end selected by the bit order, so the first bit received finishes at [WIDTH-1] (MSB-first) or at [0] (LSB-first).
    always_comb begin
        if (MSB_FIRST) begin
            w_shifted = {r_shift[WIDTH-2:0], sin};
        end else begin
            w_shifted = {sin, r_shift[WIDTH-1:1]};
        end
    end

    // Next-state logic. It also computes the next count and shift value, and detects a completed word.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_complete  = 1'b0;
        w_word      = w_shifted;
`ifdef SIPO_RX_PARITY_EN
        w_perr      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                // A strobe that arrives with start is not a data bit.
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    // Restart the frame: drop the partial word.
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end else if (sin_en) begin
                    w_shift_nxt = w_shifted;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_cnt_nxt   = CNT_W'(WIDTH);
`else
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
`ifdef SIPO_RX_PARITY_EN
            ST_PARITY: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                end else if (sin_en) begin
                    // The data bits are already in place, so this strobe carries the parity bit.
                    w_complete  = 1'b1;
                    w_word      = r_shift;
                    w_perr      = ^{r_shift, sin};
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_shift_nxt = '0;
            end
        endcase
    end

    // A completed word may load when the output is empty, or when the held word is taken in the same cycle.
    assign w_accept = !pout_valid || pout_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Output word register: load, drop with sticky overrun, or clear valid on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            pout       <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_complete) begin
            if (w_accept) begin
                pout       <= w_word;
                pout_valid <= 1'b1;
            end else begin
                overrun    <= 1'b1;
            end
        end else if (pout_valid && pout_ready) begin
            pout_valid <= 1'b0;
        end
    end

`ifdef SIPO_RX_PARITY_EN
    // Parity status is loaded together with pout, so it always describes the word currently held.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (w_complete && w_accept) begin
            parity_err <= w_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (r_state != ST_IDLE);

endmodule
